serial_sender: RTL and testbench
================================

SERIAL_SENDER -- requirements
Module: serial_sender

Interface
REQ-001 Parameter CLK_DIV, default 500, clk cycles per serial bit period (even, >=4; 50 MHz -> 100 kHz).
REQ-002 Parameter LANE_BITS, default 16, payload bits carried per data lane per DATA frame.
REQ-003 Parameter TIMEOUT_BITS, default 64, bit periods to wait for a matching ACK before retransmitting.
REQ-004 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  input  1  system clock (CLOCK_50).
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 game_active  input  1  when low, no new frame starts.
REQ-008 send_data  input  1  request to transmit payload; accepted only when data_ready=1.
REQ-009 payload  input  4*LANE_BITS  data word; lane k carries payload[LANE_BITS*k +: LANE_BITS].
REQ-010 send_ack  input  1  request to transmit an ACK frame.
REQ-011 ack_seq_in  input  1  sequence number placed in the requested ACK frame.
REQ-012 ack_received  input  1  one-cycle pulse from the local receiver: opponent ACK arrived.
REQ-013 ack_seqNum  input  1  sequence number of that received ACK.
REQ-014 clk_gpio_out  output  1  serial bit clock to the opponent.
REQ-015 serial_out_h, serial_out_0..serial_out_3  output  1 each  header lane and four data lanes.
REQ-016 data_ready  output  1  no unacknowledged DATA packet held.
REQ-017 busy  output  1  frame (including gap) in progress.
REQ-018 tx_seq  output  1  sequence number of the current/next DATA packet.
REQ-019 retx_count  output  4  retransmissions of the current packet, saturating at 15.

Function
REQ-020 Divider div_cnt counts 0..CLK_DIV-1 and wraps, free-running; clk_gpio_out=1 iff div_cnt>=CLK_DIV/2.
REQ-021 Lane outputs change only on the cycle div_cnt wraps to 0 (bit boundary), so they are stable at each clk_gpio_out rising edge.
REQ-022 FSM states IDLE, HEADER, PAYLOAD, GAP; transitions occur only at bit boundaries.
REQ-023 IDLE: all lanes 0; at a bit boundary with game_active=1, start ACK frame if ack pending, else DATA frame if retransmit or new-data pending, else stay.
REQ-024 HEADER: 3 bit periods on serial_out_h: 1 (start), type (0=DATA, 1=ACK), seq bit; data lanes 0.
REQ-025 PAYLOAD (DATA only): LANE_BITS bit periods, each data lane sends its slice MSB first; serial_out_h 0.
REQ-026 ACK frames go HEADER -> GAP; DATA frames go HEADER -> PAYLOAD -> GAP.
REQ-027 GAP: 2 bit periods all lanes 0, then IDLE; busy=1 from first HEADER bit through last GAP bit.
REQ-028 send_data & data_ready: latch payload, data_ready<=0 next cycle, new-data pending set; frame carries tx_seq.
REQ-029 send_ack: set ack pending, latch ack_seq_in; a later send_ack before transmission overwrites the latched seq.
REQ-030 ACK pending takes priority over DATA at frame start; a frame in progress is never preempted.
REQ-031 ack_received with ack_seqNum==tx_seq while data_ready=0: clear pending, data_ready<=1, tx_seq toggles, timeout and retx_count clear, next cycle.
REQ-032 ack_received with mismatched seq, or while data_ready=1, is ignored.
REQ-033 Matching ACK during a retransmission: frame completes unchanged; no further retransmit.
REQ-034 Timeout counter increments each bit boundary while data_ready=0 and FSM not sending DATA; at TIMEOUT_BITS sets retransmit pending, clears, and retx_count increments (saturating).
REQ-035 game_active low mid-frame: frame completes; pending state and timeout counter hold.
REQ-036 send_data and send_ack in the same cycle: both accepted.

Reset
REQ-037 rst: FSM IDLE, div_cnt 0, all lanes and clk_gpio_out 0, data_ready 1, busy 0, tx_seq 0, retx_count 0, all pending flags and timeout cleared.
REQ-038 rst mid-frame aborts it; lanes 0 on the next cycle.

Verification (CLK_DIV=4, LANE_BITS=4, TIMEOUT_BITS=8)
REQ-039 send_data with payload 16'hA5C3, tx_seq 0 -> h lane 1,0,0; lanes 3..0 send A,5,C,3 MSB first; 2 gap bits; data_ready stays 0.
REQ-040 After REQ-039, ack_received ack_seqNum=0 -> data_ready 1, tx_seq 1; ack_seqNum=1 instead -> ignored.
REQ-041 No ACK -> retransmit 8 bit periods after frame end, identical frame, retx_count 1; 20 timeouts -> retx_count 15.
REQ-042 send_ack ack_seq_in=1 and send_data same cycle -> ACK frame (1,1,1) first, then DATA frame.
REQ-043 game_active=0 with data pending -> no frame; raise game_active -> frame at next bit boundary.
REQ-044 rst during PAYLOAD -> all outputs at reset values next cycle; data_ready 1, tx_seq 0.

Source files
------------

// File: rtl/serial_sender.sv
// serial_sender: five-lane framed serial transmitter (header + 4 data lanes) with a
// stop-and-wait protocol: one outstanding DATA packet, ACK frames, timeout retransmit.
module serial_sender #(
  parameter int CLK_DIV      = 500,
  parameter int LANE_BITS    = 16,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   game_active,
  input  logic                   send_data,
  input  logic [4*LANE_BITS-1:0] payload,
  input  logic                   send_ack,
  input  logic                   ack_seq_in,
  input  logic                   ack_received,
  input  logic                   ack_seqNum,
  output logic                   clk_gpio_out,
  output logic                   serial_out_h,
  output logic                   serial_out_0,
  output logic                   serial_out_1,
  output logic                   serial_out_2,
  output logic                   serial_out_3,
  output logic                   data_ready,
  output logic                   busy,
  output logic                   tx_seq,
  output logic [3:0]             retx_count
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(LANE_BITS + 3);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam int PW = 4 * LANE_BITS;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [3:0]    retx_cnt_q, retx_cnt_d;
  logic [PW-1:0] data_q, data_d;
  logic [PW-1:0] shift_q, shift_d;
  logic          data_ready_q, data_ready_d;
  logic          tx_seq_q, tx_seq_d;
  logic          new_pend_q, new_pend_d;
  logic          retx_pend_q, retx_pend_d;
  logic          ack_pend_q, ack_pend_d;
  logic          ack_seq_q, ack_seq_d;
  logic          frm_ack_q, frm_ack_d;
  logic          frm_seq_q, frm_seq_d;

  logic tick, count_en, to_hit, ack_ok;

  assign tick   = (div_cnt_q == DW'(CLK_DIV - 1));
  assign ack_ok = ack_received && !data_ready_q && (ack_seqNum == tx_seq_q);
  // Timeout only runs while the packet is waiting on the wire for its ACK,
  // i.e. nothing queued to (re)send and no DATA frame currently going out.
  assign count_en = !data_ready_q && !new_pend_q && !retx_pend_q && game_active &&
                    !((state_q != S_IDLE) && !frm_ack_q);
  assign to_hit   = tick && count_en && (timeout_q == TW'(TIMEOUT_BITS - 1));

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    timeout_d    = timeout_q;
    retx_cnt_d   = retx_cnt_q;
    data_d       = data_q;
    shift_d      = shift_q;
    data_ready_d = data_ready_q;
    tx_seq_d     = tx_seq_q;
    new_pend_d   = new_pend_q;
    retx_pend_d  = retx_pend_q;
    ack_pend_d   = ack_pend_q;
    ack_seq_d    = ack_seq_q;
    frm_ack_d    = frm_ack_q;
    frm_seq_d    = frm_seq_q;

    if (tick && count_en) begin
      if (to_hit) begin
        timeout_d   = '0;
        retx_pend_d = 1'b1;
        if (retx_cnt_q != 4'hF) retx_cnt_d = retx_cnt_q + 1'b1;
      end else begin
        timeout_d = timeout_q + 1'b1;
      end
    end

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (game_active) begin
            if (ack_pend_q) begin
              state_d    = S_HEADER;
              bit_cnt_d  = '0;
              frm_ack_d  = 1'b1;
              frm_seq_d  = ack_seq_q;
              ack_pend_d = 1'b0;
            end else if (new_pend_q || retx_pend_q || to_hit) begin
              // Frame fields are snapshotted so a mid-frame ACK cannot alter them.
              state_d     = S_HEADER;
              bit_cnt_d   = '0;
              frm_ack_d   = 1'b0;
              frm_seq_d   = tx_seq_q;
              shift_d     = data_q;
              new_pend_d  = 1'b0;
              retx_pend_d = 1'b0;
            end
          end
        end
        S_HEADER: begin
          if (bit_cnt_q == BW'(2)) begin
            bit_cnt_d = '0;
            state_d   = frm_ack_q ? S_GAP : S_PAYLOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_PAYLOAD: begin
          for (int k = 0; k < 4; k++)
            shift_d[k*LANE_BITS +: LANE_BITS] = {shift_q[k*LANE_BITS +: LANE_BITS-1], 1'b0};
          if (bit_cnt_q == BW'(LANE_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (bit_cnt_q == BW'(1)) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (send_ack) begin
      ack_pend_d = 1'b1;
      ack_seq_d  = ack_seq_in;
    end
    if (send_data && data_ready_q) begin
      data_d       = payload;
      data_ready_d = 1'b0;
      new_pend_d   = 1'b1;
    end
    if (ack_ok) begin
      data_ready_d = 1'b1;
      tx_seq_d     = ~tx_seq_q;
      new_pend_d   = 1'b0;
      retx_pend_d  = 1'b0;
      timeout_d    = '0;
      retx_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      timeout_q    <= '0;
      retx_cnt_q   <= '0;
      data_q       <= '0;
      shift_q      <= '0;
      data_ready_q <= 1'b1;
      tx_seq_q     <= 1'b0;
      new_pend_q   <= 1'b0;
      retx_pend_q  <= 1'b0;
      ack_pend_q   <= 1'b0;
      ack_seq_q    <= 1'b0;
      frm_ack_q    <= 1'b0;
      frm_seq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      timeout_q    <= timeout_d;
      retx_cnt_q   <= retx_cnt_d;
      data_q       <= data_d;
      shift_q      <= shift_d;
      data_ready_q <= data_ready_d;
      tx_seq_q     <= tx_seq_d;
      new_pend_q   <= new_pend_d;
      retx_pend_q  <= retx_pend_d;
      ack_pend_q   <= ack_pend_d;
      ack_seq_q    <= ack_seq_d;
      frm_ack_q    <= frm_ack_d;
      frm_seq_q    <= frm_seq_d;
    end
  end

  // Lanes decode registered state that only moves on a wrap, so they are glitch-free.
  assign clk_gpio_out = (div_cnt_q >= DW'(CLK_DIV / 2));
  assign busy         = (state_q != S_IDLE);
  assign data_ready   = data_ready_q;
  assign tx_seq       = tx_seq_q;
  assign retx_count   = retx_cnt_q;
  assign serial_out_h = (state_q == S_HEADER) &&
                        ((bit_cnt_q == '0) ? 1'b1 :
                         (bit_cnt_q == BW'(1)) ? frm_ack_q : frm_seq_q);
  assign serial_out_0 = (state_q == S_PAYLOAD) && shift_q[0*LANE_BITS + LANE_BITS-1];
  assign serial_out_1 = (state_q == S_PAYLOAD) && shift_q[1*LANE_BITS + LANE_BITS-1];
  assign serial_out_2 = (state_q == S_PAYLOAD) && shift_q[2*LANE_BITS + LANE_BITS-1];
  assign serial_out_3 = (state_q == S_PAYLOAD) && shift_q[3*LANE_BITS + LANE_BITS-1];

endmodule

// File: tb/tb_serial_sender.sv
// Bench for serial_sender: a wire-level monitor decodes frames at each serial clock
// rise; tests compare decoded frames and status outputs against a protocol model.
module tb_serial_sender;
  localparam int CD = 4;
  localparam int LB = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_active = 1'b1;
  logic send_data = 1'b0;
  logic [4*LB-1:0] payload = '0;
  logic send_ack = 1'b0;
  logic ack_seq_in = 1'b0;
  logic ack_received = 1'b0;
  logic ack_seqNum = 1'b0;
  logic clk_gpio_out, serial_out_h, serial_out_0, serial_out_1, serial_out_2, serial_out_3;
  logic data_ready, busy, tx_seq;
  logic [3:0] retx_count;
  logic [3:0] dl;

  serial_sender #(.CLK_DIV(CD), .LANE_BITS(LB), .TIMEOUT_BITS(TO)) dut (
    .clk(clk), .rst(rst), .game_active(game_active), .send_data(send_data),
    .payload(payload), .send_ack(send_ack), .ack_seq_in(ack_seq_in),
    .ack_received(ack_received), .ack_seqNum(ack_seqNum), .clk_gpio_out(clk_gpio_out),
    .serial_out_h(serial_out_h), .serial_out_0(serial_out_0), .serial_out_1(serial_out_1),
    .serial_out_2(serial_out_2), .serial_out_3(serial_out_3), .data_ready(data_ready),
    .busy(busy), .tx_seq(tx_seq), .retx_count(retx_count)
  );

  always #5 clk = ~clk;
  assign dl = {serial_out_3, serial_out_2, serial_out_1, serial_out_0};

  typedef struct {
    logic          typ;
    logic          seq;
    logic [4*LB-1:0] data;
    int            start_b;
    int            end_b;
    bit            clean;
  } frame_t;

  frame_t fq[$];
  frame_t cur;
  int     bitn = 0;
  int     mph = 0;
  int     mk = 0;
  int     idle_glitch = 0;
  logic   prev_g = 1'b0;

  int total = 0;
  int passed = 0;
  logic model_seq = 1'b0;

  // Wire-level frame decoder: one sample per serial bit period.
  always @(negedge clk) begin
    if (rst) begin
      mph = 0; mk = 0; prev_g = 1'b0;
    end else begin
      if (clk_gpio_out && !prev_g) begin
        bitn++;
        case (mph)
          0: begin
            if (dl != 4'h0) idle_glitch++;
            if (serial_out_h) begin
              cur.typ = 1'b0; cur.seq = 1'b0; cur.data = '0; cur.clean = 1'b1;
              cur.start_b = bitn; cur.end_b = bitn; mk = 1; mph = 1;
            end
          end
          1: begin
            if (dl != 4'h0) cur.clean = 1'b0;
            if (mk == 1) begin
              cur.typ = serial_out_h; mk = 2;
            end else begin
              cur.seq = serial_out_h; cur.end_b = bitn; mk = 0;
              mph = cur.typ ? 3 : 2;
            end
          end
          2: begin
            if (serial_out_h) cur.clean = 1'b0;
            for (int k = 0; k < 4; k++) cur.data[LB*k + LB-1-mk] = dl[k];
            mk++;
            if (mk == LB) begin cur.end_b = bitn; mk = 0; mph = 3; end
          end
          default: begin
            if (serial_out_h || dl != 4'h0) cur.clean = 1'b0;
            mk++;
            if (mk == 2) begin fq.push_back(cur); mk = 0; mph = 0; end
          end
        endcase
      end
      prev_g = clk_gpio_out;
    end
  end

  task automatic send_d(input logic [4*LB-1:0] p);
    @(negedge clk); payload = p; send_data = 1'b1;
    @(negedge clk); send_data = 1'b0;
  endtask

  task automatic ack_rx(input logic s);
    @(negedge clk); ack_seqNum = s; ack_received = 1'b1;
    @(negedge clk); ack_received = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      #1;
      if (fq.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_busy(input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (busy === v) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({clk_gpio_out, serial_out_h, dl} !== 6'h0) $display("FAIL reset_lanes got %h want 0", {clk_gpio_out, serial_out_h, dl}); else passed++;
    total++; if (data_ready !== 1'b1) $display("FAIL reset_data_ready got %b want 1", data_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if ({tx_seq, retx_count} !== 5'h0) $display("FAIL reset_seq_retx got %h want 0", {tx_seq, retx_count}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_clk_div;
    int first, second;
    logic pg;
    int hi;
    first = -1; second = -1; pg = clk_gpio_out; hi = 0;
    for (int c = 0; c < 4*CD; c++) begin
      @(negedge clk);
      if (clk_gpio_out && !pg) begin
        if (first < 0) first = c; else if (second < 0) second = c;
      end
      if (first >= 0 && second < 0 && clk_gpio_out) hi++;
      pg = clk_gpio_out;
    end
    total++; if (second - first !== CD) $display("FAIL clk_period got %0d want %0d", second - first, CD); else passed++;
    total++; if (hi !== CD/2) $display("FAIL clk_high got %0d want %0d", hi, CD/2); else passed++;
  endtask

  task automatic test_data_frame;
    bit ok;
    fq.delete();
    send_d(16'hA5C3);
    total++; if (data_ready !== 1'b0) $display("FAIL data_accept got %b want 0", data_ready); else passed++;
    wait_frames(1, 200, ok);
    total++; if (!ok) $display("FAIL data_frame_seen got none want 1 frame"); else passed++;
    if (ok) begin
      total++;
      if ({fq[0].typ, fq[0].seq, fq[0].data, fq[0].clean} !== {1'b0, model_seq, 16'hA5C3, 1'b1})
        $display("FAIL data_frame got %h want %h", {fq[0].typ, fq[0].seq, fq[0].data, fq[0].clean}, {1'b0, model_seq, 16'hA5C3, 1'b1});
      else passed++;
    end
    total++; if (data_ready !== 1'b0) $display("FAIL data_ready_held got %b want 0", data_ready); else passed++;
  endtask

  task automatic test_ack;
    ack_rx(~model_seq);
    total++; if ({data_ready, tx_seq} !== {1'b0, model_seq}) $display("FAIL ack_mismatch got %b want %b", {data_ready, tx_seq}, {1'b0, model_seq}); else passed++;
    ack_rx(model_seq);
    model_seq = ~model_seq;
    total++; if ({data_ready, tx_seq, retx_count} !== {1'b1, model_seq, 4'h0}) $display("FAIL ack_match got %h want %h", {data_ready, tx_seq, retx_count}, {1'b1, model_seq, 4'h0}); else passed++;
    ack_rx(model_seq);
    total++; if ({data_ready, tx_seq} !== {1'b1, model_seq}) $display("FAIL ack_while_ready got %b want %b", {data_ready, tx_seq}, {1'b1, model_seq}); else passed++;
    fq.delete();
    repeat (40*CD) @(negedge clk);
    total++; if (fq.size() !== 0) $display("FAIL ack_no_retx got %0d frames want 0", fq.size()); else passed++;
  endtask

  task automatic test_retransmit;
    bit ok;
    logic [4*LB-1:0] p;
    p = 16'($urandom);
    fq.delete();
    send_d(p);
    wait_frames(1, 200, ok);
    total++; if (!ok) $display("FAIL retx_first got none want 1 frame"); else passed++;
    for (int k = 1; k <= 20 && ok; k++) begin
      wait_frames(k + 1, 400, ok);
      total++; if (!ok) $display("FAIL retx_seen_%0d got none want frame", k); else passed++;
      if (ok) begin
        total++;
        if ({fq[k].typ, fq[k].seq, fq[k].data, fq[k].clean} !== {1'b0, model_seq, p, 1'b1})
          $display("FAIL retx_frame_%0d got %h want %h", k, {fq[k].typ, fq[k].seq, fq[k].data, fq[k].clean}, {1'b0, model_seq, p, 1'b1});
        else passed++;
        // retransmit header follows 2 gap bits plus TO idle bit periods
        if (k == 1) begin
          total++;
          if (fq[1].start_b - fq[0].end_b !== 2 + TO + 1)
            $display("FAIL retx_timing got %0d want %0d", fq[1].start_b - fq[0].end_b, 2 + TO + 1);
          else passed++;
        end
        total++; if (retx_count !== 4'((k > 15) ? 15 : k)) $display("FAIL retx_count_%0d got %0d want %0d", k, retx_count, (k > 15) ? 15 : k); else passed++;
      end
    end
    ack_rx(model_seq);
    model_seq = ~model_seq;
    total++; if ({data_ready, retx_count} !== {1'b1, 4'h0}) $display("FAIL retx_clear got %h want %h", {data_ready, retx_count}, {1'b1, 4'h0}); else passed++;
    wait_busy(1'b0, 200, ok);
  endtask

  task automatic test_ack_during_retx;
    bit ok;
    logic [4*LB-1:0] p;
    logic s;
    p = 16'($urandom);
    s = model_seq;
    fq.delete();
    send_d(p);
    wait_frames(1, 200, ok);
    wait_busy(1'b0, 100, ok);
    wait_busy(1'b1, 200, ok);
    total++; if (!ok) $display("FAIL midretx_start got busy %b want 1", busy); else passed++;
    repeat (2*CD) @(negedge clk);
    ack_rx(s);
    model_seq = ~model_seq;
    total++; if ({data_ready, busy} !== 2'b11) $display("FAIL midretx_ack got %b want 11", {data_ready, busy}); else passed++;
    wait_frames(2, 300, ok);
    total++; if (!ok) $display("FAIL midretx_seen got none want frame"); else passed++;
    if (ok) begin
      total++;
      if ({fq[1].typ, fq[1].seq, fq[1].data, fq[1].clean} !== {1'b0, s, p, 1'b1})
        $display("FAIL midretx_frame got %h want %h", {fq[1].typ, fq[1].seq, fq[1].data, fq[1].clean}, {1'b0, s, p, 1'b1});
      else passed++;
    end
    repeat (40*CD) @(negedge clk);
    total++; if (fq.size() !== 2) $display("FAIL midretx_no_more got %0d frames want 2", fq.size()); else passed++;
  endtask

  task automatic test_ack_priority;
    bit ok;
    logic [4*LB-1:0] p;
    p = 16'($urandom);
    fq.delete();
    @(negedge clk); payload = p; send_data = 1'b1; send_ack = 1'b1; ack_seq_in = 1'b1;
    @(negedge clk); send_data = 1'b0; send_ack = 1'b0;
    wait_frames(2, 400, ok);
    total++; if (!ok) $display("FAIL prio_seen got %0d frames want 2", fq.size()); else passed++;
    if (ok) begin
      total++;
      if ({fq[0].typ, fq[0].seq, fq[0].clean} !== 3'b111) $display("FAIL prio_ack got %b want 111", {fq[0].typ, fq[0].seq, fq[0].clean}); else passed++;
      total++;
      if ({fq[1].typ, fq[1].seq, fq[1].data, fq[1].clean} !== {1'b0, model_seq, p, 1'b1})
        $display("FAIL prio_data got %h want %h", {fq[1].typ, fq[1].seq, fq[1].data, fq[1].clean}, {1'b0, model_seq, p, 1'b1});
      else passed++;
      total++; if (fq[1].start_b <= fq[0].end_b + 2) $display("FAIL prio_gap got %0d want > %0d", fq[1].start_b, fq[0].end_b + 2); else passed++;
    end
    ack_rx(model_seq);
    model_seq = ~model_seq;
  endtask

  task automatic test_game_active;
    bit ok;
    logic [4*LB-1:0] p;
    logic pg;
    int b;
    p = 16'($urandom);
    game_active = 1'b0;
    fq.delete();
    send_d(p);
    @(negedge clk); send_ack = 1'b1; ack_seq_in = 1'b1;
    @(negedge clk); ack_seq_in = 1'b0;
    @(negedge clk); send_ack = 1'b0;
    repeat (15*CD) @(negedge clk);
    total++; if ({fq.size() != 0, busy} !== 2'b00) $display("FAIL ga_hold got %b want 00", {fq.size() != 0, busy}); else passed++;
    pg = clk_gpio_out;
    ok = 1'b0;
    for (int c = 0; c < 4*CD && !ok; c++) begin
      @(negedge clk);
      if (clk_gpio_out && !pg) ok = 1'b1;
      pg = clk_gpio_out;
    end
    #1;
    b = bitn;
    game_active = 1'b1;
    wait_frames(2, 400, ok);
    total++; if (!ok) $display("FAIL ga_seen got %0d frames want 2", fq.size()); else passed++;
    if (ok) begin
      total++; if ({fq[0].typ, fq[0].seq, fq[0].clean} !== 3'b101) $display("FAIL ga_ack_overwrite got %b want 101", {fq[0].typ, fq[0].seq, fq[0].clean}); else passed++;
      total++; if (fq[0].start_b !== b + 1) $display("FAIL ga_start got %0d want %0d", fq[0].start_b, b + 1); else passed++;
      total++;
      if ({fq[1].typ, fq[1].seq, fq[1].data} !== {1'b0, model_seq, p})
        $display("FAIL ga_data got %h want %h", {fq[1].typ, fq[1].seq, fq[1].data}, {1'b0, model_seq, p});
      else passed++;
    end
    ack_rx(model_seq);
    model_seq = ~model_seq;
  endtask

  task automatic test_reset_mid;
    bit ok;
    fq.delete();
    send_d(16'($urandom));
    wait_busy(1'b1, 100, ok);
    repeat (3*CD + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({clk_gpio_out, serial_out_h, dl, busy} !== 7'h0) $display("FAIL rstmid_lanes got %h want 0", {clk_gpio_out, serial_out_h, dl, busy}); else passed++;
    total++; if ({data_ready, tx_seq, retx_count} !== {1'b1, 5'h0}) $display("FAIL rstmid_status got %h want %h", {data_ready, tx_seq, retx_count}, {1'b1, 5'h0}); else passed++;
    rst = 1'b0;
    model_seq = 1'b0;
    fq.delete();
    repeat (40*CD) @(negedge clk);
    total++; if (fq.size() !== 0) $display("FAIL rstmid_no_frame got %0d want 0", fq.size()); else passed++;
  endtask

  task automatic test_random;
    bit ok;
    frame_t exp_q[$];
    frame_t e;
    logic [4*LB-1:0] p;
    logic do_ack, as;
    for (int it = 0; it < 6; it++) begin
      p = 16'($urandom);
      do_ack = 1'($urandom_range(0, 1));
      as = 1'($urandom_range(0, 1));
      exp_q.delete();
      fq.delete();
      if (do_ack) begin e.typ = 1'b1; e.seq = as; e.data = '0; exp_q.push_back(e); end
      e.typ = 1'b0; e.seq = model_seq; e.data = p; exp_q.push_back(e);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      @(negedge clk); payload = p; send_data = 1'b1; send_ack = do_ack; ack_seq_in = as;
      @(negedge clk); send_data = 1'b0; send_ack = 1'b0;
      wait_frames(exp_q.size(), 400, ok);
      total++; if (!ok) $display("FAIL rnd_seen_%0d got %0d want %0d", it, fq.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && ok; i++) begin
        total++;
        if ({fq[i].typ, fq[i].seq, fq[i].data, fq[i].clean} !== {exp_q[i].typ, exp_q[i].seq, exp_q[i].data, 1'b1})
          $display("FAIL rnd_frame_%0d_%0d got %h want %h", it, i, {fq[i].typ, fq[i].seq, fq[i].data, fq[i].clean}, {exp_q[i].typ, exp_q[i].seq, exp_q[i].data, 1'b1});
        else passed++;
      end
      if ($urandom_range(0, 1) == 1) begin
        ack_rx(~model_seq);
        total++; if (data_ready !== 1'b0) $display("FAIL rnd_badack_%0d got %b want 0", it, data_ready); else passed++;
      end
      ack_rx(model_seq);
      model_seq = ~model_seq;
      total++; if ({data_ready, tx_seq} !== {1'b1, model_seq}) $display("FAIL rnd_ack_%0d got %b want %b", it, {data_ready, tx_seq}, {1'b1, model_seq}); else passed++;
    end
    total++; if (idle_glitch !== 0) $display("FAIL idle_lanes got %0d want 0", idle_glitch); else passed++;
  endtask

  initial begin
    test_reset();
    test_clk_div();
    test_data_frame();
    test_ack();
    test_retransmit();
    test_ack_during_retx();
    test_ack_priority();
    test_game_active();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
